// File: rtl/spi_pkg.sv
// Shared SPI definitions for the regfile target and its APB-driven controller.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    GAP  = 2'd2,
    DATA = 2'd3
  } spi_state_e;

  localparam int SPI_FRAME_BITS = 8;
  localparam int SPI_WR_BIT     = 7;
  localparam int SPI_GAP_CYCLES = 10;

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between the controller (master) and the regfile target (slave).
interface spi_slave_regfile_if;
  logic s_clk;
  logic mosi;
  logic cs_n;
  logic miso;

  modport master (output s_clk, output mosi, output cs_n, input miso);
  modport slave  (input s_clk, input mosi, input cs_n, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer: one input gets rising-edge detection, the rest are plain level syncs.
module spi_sync_edge #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_edge,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_rise,
  output logic [WIDTH-1:0] o_q
);

  logic             r_edge_meta;
  logic             r_edge_sync;
  logic             r_edge_prev;
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Edge input resets high so an idle-high s_clk never shows a false rise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_edge_meta <= 1'b1;
      r_edge_sync <= 1'b1;
      r_edge_prev <= 1'b1;
      r_meta      <= RST_VAL;
      r_sync      <= RST_VAL;
    end else begin
      r_edge_meta <= i_edge;
      r_edge_sync <= r_edge_meta;
      r_edge_prev <= r_edge_sync;
      r_meta      <= i_d;
      r_sync      <= r_meta;
    end
  end

  assign o_rise = r_edge_sync & ~r_edge_prev;
  assign o_q    = r_sync;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI target with a local register file: address frame, gap, data frame; bit 7 of address = write.
// Optional SPI_SLAVE_STATS_EN adds o_frame_cnt (wrapping) and o_abort_cnt (saturating).
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int                  NUM_BITS     = SPI_FRAME_BITS,
  parameter int                  NUM_REGS     = 16,
  parameter int                  TIMEOUT      = 64,
  parameter logic [NUM_BITS-1:0] RD_MISS_DATA = {NUM_BITS{1'b1}}
) (
  input  logic                        clk,
  input  logic                        rstn,
  spi_slave_regfile_if.slave          spi,
  input  logic [$clog2(NUM_REGS)-1:0] i_host_raddr,
  output logic [NUM_BITS-1:0]         o_host_rdata,
  output logic                        o_wr_valid,
  output logic [6:0]                  o_wr_addr,
  output logic [NUM_BITS-1:0]         o_wr_data,
  output logic                        o_addr_err
`ifdef SPI_SLAVE_STATS_EN
  ,
  output logic [15:0]                 o_frame_cnt,
  output logic [7:0]                  o_abort_cnt
`endif
);

  localparam int BW = $clog2(NUM_BITS);
  localparam int IW = $clog2(NUM_REGS);
  localparam int TW = $clog2(TIMEOUT + 1);

  spi_state_e          r_state, w_state_nxt;
  logic [BW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [NUM_BITS-1:0] r_addr_sh, w_addr_nxt;
  logic [NUM_BITS-1:0] r_data_sh, w_data_nxt;
  logic [NUM_BITS-1:0] r_tx_sh, w_tx_nxt;
  logic                r_miso, w_miso_nxt;
  logic [TW-1:0]       r_to_cnt, w_to_nxt;
  logic                r_addr_err, w_err_nxt;
  logic                r_wr_valid;
  logic [6:0]          r_wr_addr;
  logic [NUM_BITS-1:0] r_wr_data;
  logic [NUM_BITS-1:0] r_host_rdata;
  logic [NUM_BITS-1:0] r_regs [NUM_REGS];

  logic                w_rise, w_mosi, w_cs_n, w_commit;
  logic [1:0]          w_sync;
  logic [6:0]          w_idx;
  logic                w_in_range, w_is_wr, w_last, w_to_en, w_timeout;
  logic [NUM_BITS-1:0] w_tx_load;

  spi_sync_edge #(.WIDTH(2), .RST_VAL(2'b10)) u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .i_edge (spi.s_clk),
    .i_d    ({spi.cs_n, spi.mosi}),
    .o_rise (w_rise),
    .o_q    (w_sync)
  );

  assign w_mosi     = w_sync[0];
  assign w_cs_n     = w_sync[1];
  assign w_idx      = r_addr_sh[6:0];
  assign w_in_range = (int'(w_idx) < NUM_REGS);
  assign w_is_wr    = r_addr_sh[SPI_WR_BIT];
  assign w_last     = (r_bit_cnt == BW'(NUM_BITS - 1));
  assign w_tx_load  = w_in_range ? r_regs[w_idx[IW-1:0]] : RD_MISS_DATA;
  // GAP is exempt: the controller's gap has no bound in clk cycles.
  assign w_to_en    = (r_state == ADDR) || ((r_state == DATA) && (r_bit_cnt != '0));
  assign w_timeout  = w_to_en && !w_rise && (r_to_cnt == TW'(TIMEOUT - 1));

  // Next-state, shift registers and miso; aborts take priority over any edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_addr_nxt    = r_addr_sh;
    w_data_nxt    = r_data_sh;
    w_tx_nxt      = r_tx_sh;
    w_miso_nxt    = r_miso;
    w_err_nxt     = r_addr_err;
    w_commit      = 1'b0;
    w_to_nxt      = (w_rise || !w_to_en) ? '0 : r_to_cnt + TW'(1);
    if (w_cs_n || w_timeout) begin
      w_state_nxt   = IDLE;
      w_bit_cnt_nxt = '0;
      w_miso_nxt    = 1'b1;
      w_to_nxt      = '0;
    end else if (w_rise) begin
      w_bit_cnt_nxt = r_bit_cnt + BW'(1);
      case (r_state)
        IDLE: begin
          w_addr_nxt[0] = w_mosi;
          w_bit_cnt_nxt = BW'(1);
          w_state_nxt   = ADDR;
        end
        ADDR: begin
          w_addr_nxt[r_bit_cnt] = w_mosi;
          if (w_last) begin
            w_state_nxt   = GAP;
            w_bit_cnt_nxt = '0;
            if (!w_mosi) begin
              w_tx_nxt   = w_tx_load;
              w_miso_nxt = w_tx_load[0];
              w_err_nxt  = r_addr_err | ~w_in_range;
            end else begin
              w_miso_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ADDR;
          end
        end
        GAP: begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = BW'(1);
          if (w_is_wr) begin
            w_data_nxt[0] = w_mosi;
          end else begin
            w_miso_nxt = r_tx_sh[1];
          end
        end
        DATA: begin
          w_data_nxt[r_bit_cnt] = w_mosi;
          if (w_last) begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
            w_miso_nxt    = 1'b1;
            w_commit      = w_is_wr & w_in_range;
            w_err_nxt     = r_addr_err | (w_is_wr & ~w_in_range);
          end else if (!w_is_wr) begin
            // The controller samples on the next rise, so present the following bit now.
            w_miso_nxt = r_tx_sh[r_bit_cnt + BW'(1)];
          end else begin
            w_miso_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM and datapath state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_addr_sh  <= '0;
      r_data_sh  <= '0;
      r_tx_sh    <= '0;
      r_miso     <= 1'b1;
      r_to_cnt   <= '0;
      r_addr_err <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_addr_sh  <= w_addr_nxt;
      r_data_sh  <= w_data_nxt;
      r_tx_sh    <= w_tx_nxt;
      r_miso     <= w_miso_nxt;
      r_to_cnt   <= w_to_nxt;
      r_addr_err <= w_err_nxt;
      r_wr_valid <= w_commit;
      if (w_commit) begin
        r_wr_addr <= w_idx;
        r_wr_data <= w_data_nxt;
      end
    end
  end

  // Register file and host read port; a same-cycle commit is seen by the host one clk later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_commit) r_regs[w_idx[IW-1:0]] <= w_data_nxt;
      r_host_rdata <= (int'(i_host_raddr) < NUM_REGS) ? r_regs[i_host_raddr] : '0;
    end
  end

  assign spi.miso     = r_miso;
  assign o_wr_valid   = r_wr_valid;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_addr_err   = r_addr_err;
  assign o_host_rdata = r_host_rdata;

`ifdef SPI_SLAVE_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_abort_cnt;
  logic        w_frame_done, w_abort;

  assign w_frame_done = w_rise && !w_cs_n && (r_state == DATA) && w_last;
  assign w_abort      = (w_cs_n && (r_state != IDLE)) || w_timeout;

  // Frame counter wraps; abort counter saturates.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_frame_cnt <= 16'd0;
      r_abort_cnt <= 8'd0;
    end else begin
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_abort && (r_abort_cnt != 8'hFF)) r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_abort_cnt = r_abort_cnt;
`endif

endmodule
